// File: rtl/multicycle_alu_if.sv
// Request/result bundle between the execute-stage controller and multicycle_alu.
// The master drives the operation request and the slave (the ALU) returns the result and flags.
interface multicycle_alu_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [3:0]           Function;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   Out;
    logic                 O;
    logic                 Z;
    logic                 N;
    logic                 div_zero;

    modport master (
        output start, A, B, Function,
        input  busy, done, Out, O, Z, N, div_zero
    );

    modport slave (
        input  start, A, B, Function,
        output busy, done, Out, O, Z, N, div_zero
    );
endinterface

// File: rtl/multicycle_alu.sv
// Registered execute-stage ALU: single-cycle logic/add ops plus iterative
// shift-add multiply and restoring divide on operand magnitudes, sign-corrected at the end.
module multicycle_alu #(
    parameter int WIDTH    = 16,
    parameter bit MUL_ITER = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]         state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   acc_hi_reg;
    logic [WIDTH-1:0]   acc_lo_reg;
    logic [WIDTH-1:0]   m_reg;
    logic               is_div_reg;
    logic               q_neg_reg;
    logic               r_neg_reg;
    logic               ovf_reg;
    logic               eq_reg;

    logic               busy_reg;
    logic               done_reg;
    logic [2*WIDTH-1:0] out_reg;
    logic               o_reg;
    logic               z_reg;
    logic               n_reg;
    logic               dz_reg;

    // Operand decode on the live request; only meaningful on the start edge.
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               is_mul;
    logic               is_div;
    logic               b_zero;
    logic               go_iter;
    logic               div_ovf;

    assign a_neg   = bus.A[WIDTH-1];
    assign b_neg   = bus.B[WIDTH-1];
    assign a_mag   = a_neg ? -bus.A : bus.A;
    assign b_mag   = b_neg ? -bus.B : bus.B;
    assign is_mul  = (bus.Function == 4'b0100);
    assign is_div  = (bus.Function == 4'b0101);
    assign b_zero  = (bus.B == '0);
    assign go_iter = (is_div && !b_zero) || (is_mul && MUL_ITER);
    assign div_ovf = is_div && (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);

    // Single-cycle results
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH:0]     uadd_sum;
    logic [2*WIDTH-1:0] mul_full;
    logic [2*WIDTH-1:0] sc_out;
    logic               sc_o;
    logic               sc_dz;

    assign add_sum  = {bus.A[WIDTH-1], bus.A} + {bus.B[WIDTH-1], bus.B};
    assign sub_diff = {bus.A[WIDTH-1], bus.A} - {bus.B[WIDTH-1], bus.B};
    assign uadd_sum = {1'b0, bus.A} + {1'b0, bus.B};
    assign mul_full = $signed({{WIDTH{bus.A[WIDTH-1]}}, bus.A})
                    * $signed({{WIDTH{bus.B[WIDTH-1]}}, bus.B});

    always_comb begin
        sc_out = '0;
        sc_o   = 1'b0;
        sc_dz  = 1'b0;
        case (bus.Function)
            4'b0000: begin
                sc_out = {{(WIDTH-1){add_sum[WIDTH]}}, add_sum};
                sc_o   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0001: begin
                sc_out = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
                sc_o   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0100: sc_out = mul_full;
            // Reached only for a zero divisor; real divides go iterative.
            4'b0101: begin
                sc_out = {bus.A, {WIDTH{1'b1}}};
                sc_dz  = 1'b1;
            end
            4'b1000: sc_out = {{WIDTH{1'b0}}, bus.A & bus.B};
            4'b1001: sc_out = {{WIDTH{1'b0}}, bus.A | bus.B};
            4'b1100, 4'b1111: sc_out = {{(WIDTH-1){1'b0}}, uadd_sum};
            4'b1101: sc_out = {bus.A, bus.B};
            4'b1110: sc_out = {{WIDTH{1'b0}}, bus.B};
            default: sc_out = '0;
        endcase
    end

    // One iteration step: acc_hi holds partial product / remainder, acc_lo the multiplier / quotient.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;
    logic [WIDTH:0]     mul_sum;

    assign rem_sh       = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_diff     = rem_sh - {1'b0, m_reg};
    assign div_ge       = rem_sh[WIDTH] | ~div_diff[WIDTH];
    assign div_rem_next = div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_quo_next = {acc_lo_reg[WIDTH-2:0], div_ge};
    assign mul_sum      = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, m_reg} : {(WIDTH+1){1'b0}});

    // Sign correction of the magnitude results
    logic [2*WIDTH-1:0] mag_prod;
    logic [2*WIDTH-1:0] mul_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic [2*WIDTH-1:0] fin_out;

    assign mag_prod   = {acc_hi_reg, acc_lo_reg};
    assign mul_signed = q_neg_reg ? -mag_prod : mag_prod;
    assign quo_signed = q_neg_reg ? -acc_lo_reg : acc_lo_reg;
    assign rem_signed = r_neg_reg ? -acc_hi_reg : acc_hi_reg;
    assign fin_out    = is_div_reg ? {rem_signed, quo_signed} : mul_signed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            m_reg      <= '0;
            is_div_reg <= 1'b0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            eq_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            out_reg    <= '0;
            o_reg      <= 1'b0;
            z_reg      <= 1'b0;
            n_reg      <= 1'b0;
            dz_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (go_iter) begin
                            state_reg  <= ITER;
                            busy_reg   <= 1'b1;
                            cnt_reg    <= CW'(WIDTH);
                            is_div_reg <= is_div;
                            acc_hi_reg <= '0;
                            acc_lo_reg <= is_div ? a_mag : b_mag;
                            m_reg      <= is_div ? b_mag : a_mag;
                            q_neg_reg  <= a_neg ^ b_neg;
                            r_neg_reg  <= a_neg;
                            ovf_reg    <= div_ovf;
                            eq_reg     <= (bus.A == bus.B);
                        end else begin
                            done_reg <= 1'b1;
                            out_reg  <= sc_out;
                            o_reg    <= sc_o;
                            z_reg    <= (bus.A == bus.B);
                            n_reg    <= sc_out[WIDTH-1];
                            dz_reg   <= sc_dz;
                        end
                    end
                end
                ITER: begin
                    if (is_div_reg) begin
                        acc_hi_reg <= div_rem_next;
                        acc_lo_reg <= div_quo_next;
                    end else begin
                        {acc_hi_reg, acc_lo_reg} <= {mul_sum, acc_lo_reg[WIDTH-1:1]};
                    end
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    out_reg   <= fin_out;
                    o_reg     <= ovf_reg;
                    z_reg     <= eq_reg;
                    n_reg     <= fin_out[WIDTH-1];
                    dz_reg    <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.Out      = out_reg;
    assign bus.O        = o_reg;
    assign bus.Z        = z_reg;
    assign bus.N        = n_reg;
    assign bus.div_zero = dz_reg;
endmodule
